// File: rtl/conv2_relu_maxpool.sv
// conv2_relu_maxpool: ReLU followed by 2x2/stride-2 max-pool on three lockstep conv2 channels.
// Even rows fold pixel pairs into a half-width line buffer; odd rows finish each window.
module conv2_relu_maxpool #(
    parameter int IN_W   = 8,
    parameter int IN_H   = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] conv_in_1,
    input  logic [DATA_W-1:0] conv_in_2,
    input  logic [DATA_W-1:0] conv_in_3,
    output logic [DATA_W-1:0] pool_out_1,
    output logic [DATA_W-1:0] pool_out_2,
    output logic [DATA_W-1:0] pool_out_3,
    output logic              valid_out,
    output logic              frame_done
);
    localparam int CW = IN_W > 2 ? $clog2(IN_W) : 1;
    localparam int RW = IN_H > 2 ? $clog2(IN_H) : 1;
    localparam int LW = IN_W / 2;
    localparam int AW = LW > 1 ? $clog2(LW) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [AW-1:0]     li;
    logic              last_col, last_row, win_end;
    logic [DATA_W-1:0] x [3];
    logic [DATA_W-1:0] po [3];

    assign x[0]       = conv_in_1;
    assign x[1]       = conv_in_2;
    assign x[2]       = conv_in_3;
    assign pool_out_1 = po[0];
    assign pool_out_2 = po[1];
    assign pool_out_3 = po[2];
    assign li         = AW'(col >> 1);
    assign last_col   = col == CW'(IN_W - 1);
    assign last_row   = row == RW'(IN_H - 1);
    assign win_end    = row[0] & col[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in & win_end;
            frame_done <= valid_in & last_row & last_col;
            if (valid_in) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [DATA_W-1:0] r, h, hm, pm;
        logic [DATA_W-1:0] lb [LW];
        // Negative samples clamp to zero, so plain unsigned compares suffice afterwards.
        assign r  = x[i][DATA_W-1] ? '0 : x[i];
        assign hm = h > r ? h : r;
        assign pm = lb[li] > hm ? lb[li] : hm;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                h     <= '0;
                po[i] <= '0;
            end else if (valid_in) begin
                if (!col[0]) h <= r;
                if (win_end) po[i] <= pm;
            end
        end
        // Every entry is written in the even row before its odd-row read, so no reset is needed.
        always_ff @(posedge clk) begin
            if (!rst && valid_in && !row[0] && col[0]) lb[li] <= hm;
        end
    end
endmodule

// File: tb/tb_conv2_relu_maxpool.sv
// tb_conv2_relu_maxpool: directed frames into conv2_relu_maxpool with a queue scoreboard.
// A frame-store reference model predicts each window; a negedge monitor checks values and timing.
module tb_conv2_relu_maxpool;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [11:0] conv_in_1 = '0, conv_in_2 = '0, conv_in_3 = '0;
    logic [11:0] pool_out_1, pool_out_2, pool_out_3;
    logic        valid_out, frame_done;

    typedef struct {
        logic [11:0] a, b, c;
        logic        fd;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [11:0] a, b, c;
    } pix_t;

    exp_t        sb [$];
    pix_t        got [$];
    int          tests = 0, fails = 0, cyc = 0, vo_cnt = 0, fd_cnt = 0;
    int          mr = 0, mc = 0;
    logic [11:0] fr [3][8][8];

    conv2_relu_maxpool #(.IN_W(8), .IN_H(8), .DATA_W(12)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .conv_in_1(conv_in_1), .conv_in_2(conv_in_2), .conv_in_3(conv_in_3),
        .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
        .valid_out(valid_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int relu(input logic [11:0] v);
        return v[11] ? 0 : int'(v);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [11:0] pix(input int mode, input int r, input int c, input int ch, input int off);
        int v = 0;
        if (mode == 0) v = ch == 0 ? r * 8 + c + off : ch == 1 ? (7 - r) * 8 + (7 - c) : -(r * 8 + c);
        else if (mode == 1) v = -5;
        else if (ch == 0 && r < 2 && c < 2) v = (r == 0 && c == 0) ? 2047 : (r == 0) ? -2048 : (c == 0) ? 0 : 1;
        else if (ch == 0 && r < 2 && c < 4) v = (r == 1 && c == 3) ? 3 : -1;
        else if (ch == 1) v = (r == 0 && c == 1) ? 100 : 0;
        else if (ch == 2) v = (r == 1 && c == 0) ? 7 : 0;
        return 12'(v);
    endfunction

    function automatic int win(input int ch);
        return max4(relu(fr[ch][mr-1][mc-1]), relu(fr[ch][mr-1][mc]), relu(fr[ch][mr][mc-1]), relu(fr[ch][mr][mc]));
    endfunction

    task automatic idle();
        valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        exp_t e;
        valid_in  = 1'b1;
        conv_in_1 = a;
        conv_in_2 = b;
        conv_in_3 = c;
        fr[0][mr][mc] = a;
        fr[1][mr][mc] = b;
        fr[2][mr][mc] = c;
        if (mr % 2 == 1 && mc % 2 == 1) begin
            e.a   = 12'(win(0));
            e.b   = 12'(win(1));
            e.c   = 12'(win(2));
            e.fd  = mr == 7 && mc == 7;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        mc = mc == 7 ? 0 : mc + 1;
        if (mc == 0) mr = mr == 7 ? 0 : mr + 1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic frame(input int mode, input int off, input bit gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            send(pix(mode, p / 8, p % 8, 0, off), pix(mode, p / 8, p % 8, 1, off), pix(mode, p / 8, p % 8, 2, off));
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
        idle();
        chk(name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid_out) begin
            vo_cnt++;
            got.push_back('{a: pool_out_1, b: pool_out_2, c: pool_out_3});
            if (sb.size() == 0) chk("unexpected_valid_out", 1, 0);
            else begin
                e = sb.pop_front();
                chk("pool_out_1", int'(pool_out_1), int'(e.a));
                chk("pool_out_2", int'(pool_out_2), int'(e.b));
                chk("pool_out_3", int'(pool_out_3), int'(e.c));
                chk("frame_done_with_out", int'(frame_done), int'(e.fd));
                chk("out_cycle", cyc, e.cyc);
            end
        end else if (frame_done) chk("stray_frame_done", 1, 0);
        if (frame_done) fd_cnt++;
    end

    initial begin
        int bv, bf, bg;
        #12;
        chk("rst_pool_out_1", int'(pool_out_1), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // ramp frame
        bv = vo_cnt; bf = fd_cnt; bg = got.size();
        frame(0, 0, 0, 64);
        drain("ramp_drain");
        chk("ramp_outputs", vo_cnt - bv, 16);
        chk("ramp_frame_done", fd_cnt - bf, 1);
        chk("ramp_first", int'(got[bg].a), 9);
        chk("ramp_fifth", int'(got[bg+4].a), 25);
        chk("ramp_last", int'(got[bg+15].a), 63);
        // all-negative frame
        bv = vo_cnt; bg = got.size();
        frame(1, 0, 0, 64);
        drain("neg_drain");
        chk("neg_outputs", vo_cnt - bv, 16);
        chk("neg_any_ch1", int'(got[bg+7].a), 0);
        // max and sign edges
        bg = got.size();
        frame(2, 0, 0, 64);
        drain("edge_drain");
        chk("edge_max_2047", int'(got[bg].a), 2047);
        chk("edge_neg_then_3", int'(got[bg+1].a), 3);
        chk("edge_ch2_100", int'(got[bg].b), 100);
        chk("edge_ch3_7", int'(got[bg].c), 7);
        // gapped ramp
        bv = vo_cnt; bf = fd_cnt; bg = got.size();
        frame(0, 0, 1, 64);
        drain("gap_drain");
        chk("gap_outputs", vo_cnt - bv, 16);
        chk("gap_frame_done", fd_cnt - bf, 1);
        chk("gap_last", int'(got[bg+15].a), 63);
        // mid-frame reset after 21 pixels
        frame(0, 0, 0, 21);
        drain("partial_drain");
        rst = 1'b1;
        #1;
        chk("async_rst_pool_out_1", int'(pool_out_1), 0);
        chk("async_rst_valid_out", int'(valid_out), 0);
        valid_in  = 1'b1;
        conv_in_1 = 12'h7FF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        mr = 0;
        mc = 0;
        bv = vo_cnt; bf = fd_cnt; bg = got.size();
        frame(0, 0, 0, 64);
        drain("reset_drain");
        chk("reset_outputs", vo_cnt - bv, 16);
        chk("reset_frame_done", fd_cnt - bf, 1);
        chk("reset_first", int'(got[bg].a), 9);
        // back-to-back frames
        bv = vo_cnt; bf = fd_cnt; bg = got.size();
        frame(0, 0, 0, 64);
        frame(0, 100, 0, 64);
        drain("b2b_drain");
        chk("b2b_outputs", vo_cnt - bv, 32);
        chk("b2b_frame_done", fd_cnt - bf, 2);
        chk("b2b_second_first", int'(got[bg+16].a), 109);
        chk("b2b_second_last", int'(got[bg+31].a), 163);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
